// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// The master modport is the fetcher/memory-controller side; the cache is the slave.
interface icache_if;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        rollback;
  logic        instr_valid;
  logic [31:0] instr;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_done;
  logic [31:0] mc_data;

  modport master (
    output fetch_req, fetch_pc, rollback, mc_done, mc_data,
    input  instr_valid, instr, mc_req, mc_addr
  );

  modport slave (
    input  fetch_req, fetch_pc, rollback, mc_done, mc_data,
    output instr_valid, instr, mc_req, mc_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding miss.
// A rollback during a miss still completes the line fill but suppresses the response.
module icache #(
  parameter int INDEX_BITS = 8,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  icache_if.slave  bus
);

  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_MISS, S_RESP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [31:0]           r_data [LINES];
  logic                  r_instr_valid;
  logic [31:0]           r_instr;
  logic                  r_mc_req;
  logic [31:0]           r_mc_addr;
  logic                  r_abort;

  logic                  w_instr_valid_nxt;
  logic [31:0]           w_instr_nxt;
  logic                  w_mc_req_nxt;
  logic [31:0]           w_mc_addr_nxt;
  logic                  w_abort_nxt;
  logic                  w_fill;
  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_fill_idx;
  logic [TAG_BITS-1:0]   w_fill_tag;
  logic                  w_hit;
  logic                  w_unused_pc_lsb;

  assign w_idx      = bus.fetch_pc[INDEX_BITS+1:2];
  assign w_tag      = bus.fetch_pc[INDEX_BITS+2 +: TAG_BITS];
  // The outstanding miss address doubles as the latched pc for the fill.
  assign w_fill_idx = r_mc_addr[INDEX_BITS+1:2];
  assign w_fill_tag = r_mc_addr[INDEX_BITS+2 +: TAG_BITS];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused_pc_lsb = ^bus.fetch_pc[1:0];

  always_comb begin
    w_state_nxt       = r_state;
    w_instr_valid_nxt = 1'b0;
    w_instr_nxt       = r_instr;
    w_mc_req_nxt      = r_mc_req;
    w_mc_addr_nxt     = r_mc_addr;
    w_abort_nxt       = r_abort;
    w_fill            = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!bus.rollback && bus.fetch_req) begin
          if (w_hit) begin
            w_instr_nxt       = r_data[w_idx];
            w_instr_valid_nxt = 1'b1;
            w_state_nxt       = S_RESP;
          end else begin
            w_mc_req_nxt  = 1'b1;
            w_mc_addr_nxt = {bus.fetch_pc[31:2], 2'b00};
            w_abort_nxt   = 1'b0;
            w_state_nxt   = S_MISS;
          end
        end
      end
      S_MISS: begin
        if (bus.rollback) w_abort_nxt = 1'b1;
        if (bus.mc_done) begin
          w_mc_req_nxt = 1'b0;
          w_fill       = 1'b1;
          if (!r_abort && !bus.rollback) begin
            w_instr_nxt       = bus.mc_data;
            w_instr_valid_nxt = 1'b1;
            w_state_nxt       = S_RESP;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_mc_req      <= 1'b0;
      r_mc_addr     <= '0;
      r_abort       <= 1'b0;
      r_valid       <= '0;
    end else if (rdy) begin
      r_state       <= w_state_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_instr       <= w_instr_nxt;
      r_mc_req      <= w_mc_req_nxt;
      r_mc_addr     <= w_mc_addr_nxt;
      r_abort       <= w_abort_nxt;
      if (w_fill) r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst && rdy && w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= bus.mc_data;
    end
  end

  assign bus.instr_valid = r_instr_valid;
  assign bus.instr       = r_instr;
  assign bus.mc_req      = r_mc_req;
  assign bus.mc_addr     = r_mc_addr;

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, word-per-line instruction cache between the instruction fetcher and the memory controller.
- Takes one fetch request at a time: pc in, 32-bit instruction out with a one-cycle valid pulse.
- On a miss, issues a word read to the memory controller, fills the line, then responds.
- ROB rollback abandons an outstanding response without corrupting the memory transaction.

Parameters:
- INDEX_BITS, 8: line index width; the cache holds 2^INDEX_BITS one-word lines.
- TAG_BITS, 30-INDEX_BITS (default 22): tag width, pc[31:INDEX_BITS+2].

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global ready; low freezes all state
- fetch_req  in  1  fetcher requests an instruction at fetch_pc
- fetch_pc  in  32  instruction address; bits [1:0] are ignored
- instr_valid  out  1  one-cycle pulse: instr is valid
- instr  out  32  fetched instruction
- mc_req  out  1  read request to the memory controller; level, held until mc_done
- mc_addr  out  32  word-aligned read address, {pc[31:2],2'b00}
- mc_done  in  1  one-cycle pulse: mc_data is valid
- mc_data  in  32  word returned by the memory controller
- rollback  in  1  ROB mispredict flush

Behaviour:
- Clock and reset: clk, with rst synchronous and active-high.
- Address split: index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2].
- Storage: valid[2^INDEX_BITS], tag array, data array.
  - Only the valid bits are reset (all to 0).
  - Tag and data arrays are not reset.
- Reset values:
  - state = IDLE
  - instr_valid = 0, instr = 0
  - mc_req = 0, mc_addr = 0
  - abort flag = 0
- rdy low: no state, array, or output register changes. The memory controller never pulses mc_done while rdy is low.
- State IDLE:
  - If rollback is high, do not accept; stay in IDLE.
  - Else if fetch_req is high and the lookup hits (valid[index] and tag match):
    - instr <= data[index], instr_valid <= 1, go to RESP.
    - Hit latency: request in cycle N, instr_valid in cycle N+1.
  - Else if fetch_req is high and the lookup misses:
    - mc_req <= 1, mc_addr <= word-aligned fetch_pc.
    - Latch the pc; clear the abort flag; go to MISS.
  - Else stay in IDLE.
- State MISS:
  - mc_req and mc_addr are held stable.
  - rollback high (any cycle, including the mc_done cycle) sets the abort flag.
  - On mc_done:
    - mc_req <= 0.
    - Write data[index] <= mc_data, tag[index] <= latched tag, valid[index] <= 1. The line is filled even when aborted.
    - If not aborted (abort flag and rollback both low): instr <= mc_data, instr_valid <= 1, go to RESP.
    - If aborted: instr_valid stays 0, go to IDLE.
  - Miss latency: mc_done in cycle M, instr_valid in cycle M+1.
- State RESP:
  - instr_valid <= 0; go to IDLE.
  - fetch_req is ignored here. This guarantees one non-accepting cycle after each response, giving the fetcher time to present its next pc.
  - instr holds its value until the next response.
- Rollback coinciding with instr_valid: the response is still emitted; discarding it is the fetcher's job.
- Response count: at most one instr_valid per accepted request; none for aborted requests.
- Reset during MISS: state returns to IDLE and mc_req drops in the same edge. The memory controller is reset concurrently, so no stale mc_done follows.
- Conflict misses: a new tag at the same index overwrites the line (no replacement choice).
- Ordering: a request arriving while in MISS or RESP is not accepted. The fetcher holds fetch_req and fetch_pc until it sees instr_valid.

Test Plan:
- Cold miss, then hit:
  - After reset, fetch_pc=0x00000000 with fetch_req=1 → mc_req=1 with mc_addr=0x0.
  - Bench pulses mc_done with mc_data=0x00000013 three cycles later → instr_valid=1 with instr=0x00000013 on the next cycle, then low.
  - Re-request 0x0 → instr_valid one cycle after acceptance, mc_req stays 0.
- Conflict: with INDEX_BITS=8, fill 0x00000004, then request 0x00000404 (same index, new tag) → miss issued.
  - Afterwards, re-requesting 0x00000004 misses again.
- Rollback during miss: rollback pulses 2 cycles after mc_req rises → mc_req stays high until mc_done.
  - No instr_valid is produced; state returns to IDLE.
  - A later request to the same pc hits.
- Rollback in IDLE: fetch_req=1 and rollback=1 in the same cycle → no acceptance, no mc_req, no instr_valid.
  - Next cycle, with rollback=0 → the request is accepted.
- rdy stall: rdy=0 for 3 cycles during MISS and during RESP → all outputs frozen.
  - instr_valid stays high for exactly one rdy-high cycle.
- Reset mid-miss: rst=1 while mc_req=1 → next cycle mc_req=0, instr_valid=0, and all lines invalid; re-fetching 0x0 misses.
